// File: rtl/alu_arbiter.sv
// Shares one combinational 4-bit ALU among NREQ requesters, round-robin grant.
// ALU_ARB_FIXED_PRIO_EN selects fixed priority (requester 0 highest).
module alu_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [4*NREQ-1:0] req_a,
  input  logic [4*NREQ-1:0] req_b,
  input  logic [3*NREQ-1:0] req_s,
  output logic [3:0]        alu_a,
  output logic [3:0]        alu_b,
  output logic [2:0]        alu_s,
  input  logic [7:0]        alu_y,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [7:0]        rsp_y,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t         state;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] grant_id;
  logic [IDW-1:0] win;
  logic           found;
  logic [3:0]     sel_a;
  logic [3:0]     sel_b;
  logic [2:0]     sel_s;

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        found = 1'b1;
        win   = IDW'(i);
      end
    end
  end
`else
  // Search starts just past the last winner and wraps.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end
`endif

  always_comb begin
    sel_a     = '0;
    sel_b     = '0;
    sel_s     = '0;
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IDW'(i)) begin
        sel_a        = req_a[4*i +: 4];
        sel_b        = req_b[4*i +: 4];
        sel_s        = req_s[3*i +: 3];
        req_ready[i] = found && (state == IDLE);
      end
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= IDW'(NREQ - 1);
      grant_id   <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_s      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_y      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            alu_a      <= sel_a;
            alu_b      <= sel_b;
            alu_s      <= sel_s;
            grant_id   <= win;
            last_grant <= win;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_y     <= alu_y;
          rsp_id    <= grant_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a local ALU model on alu_y.
// Directed vectors; a negedge monitor checks every response handshake.
module tb_alu_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [4*NREQ-1:0] req_a;
  logic [4*NREQ-1:0] req_b;
  logic [3*NREQ-1:0] req_s;
  logic [3:0]        alu_a;
  logic [3:0]        alu_b;
  logic [2:0]        alu_s;
  logic [7:0]        alu_y;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_y;
  logic              busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [IDW-1:0] id;
    logic [7:0]     y;
  } exp_t;

  exp_t exp_q[$];

  alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_s(req_s),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
    .alu_y(alu_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_y(rsp_y), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_fn(
    input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
    logic [7:0] y;
    case (s)
      3'd0: y = {4'b0, a} + {4'b0, b};
      3'd1: y = {4'b0, a} - {4'b0, b};
      3'd2: y = {4'b0, a & b};
      3'd3: y = {4'b0, a | b};
      3'd4: y = {4'b0, a ^ b};
      3'd5: y = {4'b0, a} * {4'b0, b};
      3'd6: y = {a, b};
      default: y = ~{a, b};
    endcase
    return y;
  endfunction

  assign alu_y = alu_fn(alu_a, alu_b, alu_s);

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] a,
                         input logic [3:0] b, input logic [2:0] s);
    req_a[4*i +: 4] = a;
    req_b[4*i +: 4] = b;
    req_s[3*i +: 3] = s;
  endtask

  task automatic push(input int id, input logic [7:0] y);
    exp_t e;
    e.id = IDW'(id);
    e.y  = y;
    exp_q.push_back(e);
  endtask

  // Monitor: compares each completed response against the scoreboard.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_rsp: id %0d y %0h", rsp_id, rsp_y);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_y", 32'(rsp_y), 32'(e.y));
      end
    end
  end

  logic [7:0] rr_y [4];
  int w;

  initial begin
    rr_y = '{8'hF9, 8'h00, 8'h07, 8'h03};
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_s = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_y", 32'(rsp_y), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_alu_abs", 32'({alu_a, alu_b, alu_s}), 0);
    chk("rst_busy", 32'(busy), 0);

    // Single request from requester 1
    rst = 1'b0;
    set_req(1, 4'd3, 4'd5, 3'd0);
    req_valid = 4'b0010;
    #1;
    chk("t1_ready", 32'(req_ready), 32'b0010);
    push(1, 8'd8);
    tick();
    req_valid = '0;
    #1;
    chk("t1_busy1", 32'(busy), 1);
    chk("t1_alu_a", 32'(alu_a), 3);
    chk("t1_novalid", 32'(rsp_valid), 0);
    tick();
    chk("t1_busy2", 32'(busy), 1);
    chk("t1_valid", 32'(rsp_valid), 1);
    tick();
    chk("t1_idle", 32'(busy), 0);

    // Four continuous requesters, fresh round-robin state
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++)
      set_req(i, 4'(i + 2), 4'(9 - i), 3'(i + 1));
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
`ifdef ALU_ARB_FIXED_PRIO_EN
      w = 0;
`else
      w = k % 4;
`endif
      chk("rr_grant", 32'(req_ready), 32'(1) << w);
      push(w, rr_y[w]);
      tick();
      chk("rr_gap1", 32'(req_ready), 0);
      tick();
      chk("rr_gap2", 32'(req_ready), 0);
      tick();
    end
    req_valid = '0;
    tick();

    // Backpressure, operand change after grant, withdrawn request
    rsp_ready = 1'b0;
    set_req(2, 4'd7, 4'd4, 3'd2);
    req_valid = 4'b0100;
    #1;
    chk("bp_ready", 32'(req_ready), 32'b0100);
    push(2, 8'h04);
    tick();
    req_valid = '0;
    set_req(2, 4'd1, 4'd4, 3'd2);
    #1;
    chk("chg_alu_a", 32'(alu_a), 7);
    tick();
    for (int c = 0; c < 5; c++) begin
      req_valid = (c == 1) ? 4'b0010 : 4'b0000;
      #1;
      chk("bp_valid", 32'(rsp_valid), 1);
      chk("bp_id", 32'(rsp_id), 2);
      chk("bp_y", 32'(rsp_y), 32'h04);
      chk("bp_noready", 32'(req_ready), 0);
      tick();
    end
    req_valid = 4'b0001;
    set_req(0, 4'd6, 4'd3, 3'd5);
    rsp_ready = 1'b1;
    #1;
    chk("rel_noready", 32'(req_ready), 0);
    tick();
    chk("rel_next", 32'(req_ready), 32'b0001);
    push(0, 8'h12);
    tick();
    req_valid = '0;
    tick();
    tick();

    // Reset while in EXEC discards the operation
    set_req(1, 4'd9, 4'd9, 3'd0);
    req_valid = 4'b0010;
    #1;
    chk("rm_ready", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rm_valid", 32'(rsp_valid), 0);
    chk("rm_busy", 32'(busy), 0);
    chk("rm_alu", 32'({alu_a, alu_b, alu_s}), 0);
    chk("rm_id", 32'(rsp_id), 0);
    tick();
    req_valid = 4'b1001;
    #1;
    chk("rm_restart", 32'(req_ready), 32'b0001);
    push(0, 8'h12);
    tick();
    req_valid = '0;

    for (int t = 0; t < 20 && exp_q.size() != 0; t++)
      tick();
    tick();
    chk("q_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
